// File: rtl/slice_pkg.sv
// slice_pkg
//   Shared constants for the logic-slice output stage and its configuration
//   chain. The field offsets describe the default 8-bit slice:
//     cfg[SEL_SUM_LO   +: SLICE_W] : per-bit select of sum (1) vs LUT (0)
//     cfg[SEL_REG_LO   +: SLICE_W] : per-bit select of registered (1) vs
//                                    combinational (0) output
//     cfg[COUT_REG_BIT]            : carry-out registered (1) vs direct (0)
//   cfg_len() gives the chain length for any slice width.
package slice_pkg;

  localparam int SLICE_W      = 8;
  localparam int SEL_SUM_LO   = 0;
  localparam int SEL_REG_LO   = SLICE_W;
  localparam int COUT_REG_BIT = 2 * SLICE_W;
  localparam int CFG_N        = 2 * SLICE_W + 1;

  function automatic int cfg_len(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// cfg_shift_reg
//   Serial configuration shift register, shared by fabric blocks.
//   Ports:
//     clk     : clock, state updates on rising edge
//     rst_n   : asynchronous active-low reset, clears the chain
//     en_i    : shift enable; when low the chain holds
//     sin_i   : serial data in, enters at bit N-1
//     sout_o  : serial data out, bit 0 (a flop, so no path from sin_i)
//     q_o     : parallel view of the whole chain
//   Each enabled edge shifts right: q <= {sin, q[N-1:1]}, so the first bit
//   shifted in reaches bit 0 after N enabled edges.
module cfg_shift_reg #(
  parameter int N = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         sin_i,
  output logic         sout_o,
  output logic [N-1:0] q_o
);

  logic [N-1:0] sr_q;
  logic [N-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (en_i) begin
      sr_d = {sin_i, sr_q[N-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sout_o = sr_q[0];
  assign q_o    = sr_q;

endmodule

// File: rtl/slice_out_stage.sv
// slice_out_stage
//   Output stage of a logic slice: per bit, chooses LUT output or carry-chain
//   sum, then chooses the registered or combinational version for routing.
//   The carry-out has its own optional register.
//   Ports:
//     clk, rst_n : clock (rising edge) and asynchronous active-low reset
//     cfg_en     : config shift enable; while high, outputs are forced to 0
//                  and the data registers only respond to sr
//     cfg_in     : serial config in
//     cfg_out    : serial config out (daisy chain to the next slice)
//     ce         : data register clock enable
//     sr         : synchronous clear of the data registers (beats ce)
//     lut_o      : per-bit LUT outputs
//     sum        : carry-chain sum bits
//     cin_cout   : carry-chain carry-out
//     out        : slice outputs to routing
//     cout_o     : slice carry-out to routing
module slice_out_stage
  import slice_pkg::*;
#(
  parameter int W = SLICE_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_en,
  input  logic         cfg_in,
  output logic         cfg_out,
  input  logic         ce,
  input  logic         sr,
  input  logic [W-1:0] lut_o,
  input  logic [W-1:0] sum,
  input  logic         cin_cout,
  output logic [W-1:0] out,
  output logic         cout_o
);

  // Chain length follows W; it is deliberately not a separate parameter.
  localparam int CFG_LEN   = cfg_len(W);
  localparam int REG_LO    = SEL_SUM_LO + W;
  localparam int CREG_BIT  = SEL_SUM_LO + 2 * W;

  logic [CFG_LEN-1:0] cfg;
  logic [W-1:0]       sel_sum;
  logic [W-1:0]       sel_reg;
  logic               cout_reg;

  logic [W-1:0]       data_sel;
  logic [W-1:0]       q_q;
  logic [W-1:0]       q_d;
  logic               cq_q;
  logic               cq_d;

  cfg_shift_reg #(
    .N (CFG_LEN)
  ) u_cfg (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (cfg_en),
    .sin_i  (cfg_in),
    .sout_o (cfg_out),
    .q_o    (cfg)
  );

  assign sel_sum  = cfg[SEL_SUM_LO +: W];
  assign sel_reg  = cfg[REG_LO +: W];
  assign cout_reg = cfg[CREG_BIT];

  assign data_sel = (sel_sum & sum) | (~sel_sum & lut_o);

  // Registers freeze during a config load so a half-loaded select pattern
  // never captures garbage; sr still clears them.
  always_comb begin
    q_d  = q_q;
    cq_d = cq_q;
    if (sr) begin
      q_d  = '0;
      cq_d = 1'b0;
    end else if (ce && !cfg_en) begin
      q_d  = data_sel;
      cq_d = cin_cout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q  <= '0;
      cq_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      cq_q <= cq_d;
    end
  end

  // Outputs are purely combinational from the config, so a new config is
  // visible the moment cfg_en drops.
  always_comb begin
    out    = '0;
    cout_o = 1'b0;
    if (!cfg_en) begin
      out    = (sel_reg & q_q) | (~sel_reg & data_sel);
      cout_o = cout_reg ? cq_q : cin_cout;
    end
  end

endmodule

// File: tb/tb_slice_out_stage.sv
module tb_slice_out_stage;

  logic       clk;
  logic       rst_n;
  logic       cfg_en;
  logic       cfg_in;
  logic       cfg_out;
  logic       ce;
  logic       sr;
  logic [7:0] lut_o;
  logic [7:0] sum;
  logic       cin_cout;
  logic [7:0] out;
  logic       cout_o;

  int n_checks = 0;
  int n_pass   = 0;

  slice_out_stage #(.W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_en   (cfg_en),
    .cfg_in   (cfg_in),
    .cfg_out  (cfg_out),
    .ce       (ce),
    .sr       (sr),
    .lut_o    (lut_o),
    .sum      (sum),
    .cin_cout (cin_cout),
    .out      (out),
    .cout_o   (cout_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    cfg_en = 1'b1;
    cfg_in = b;
    step();
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    cfg_en   = 1'b0;
    cfg_in   = 1'b0;
    ce       = 1'b0;
    sr       = 1'b0;
    lut_o    = 8'h5A;
    sum      = 8'hC3;
    cin_cout = 1'b0;
    #3;
    n_checks++;
    if (cfg_out !== 1'b0) $display("FAIL reset_cfg_out got=%b exp=0", cfg_out);
    else n_pass++;
    n_checks++;
    if (out !== 8'h5A) $display("FAIL reset_out got=%h exp=5a", out);
    else n_pass++;
    n_checks++;
    if (cout_o !== 1'b0) $display("FAIL reset_cout got=%b exp=0", cout_o);
    else n_pass++;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_comb_path();
    lut_o    = 8'hA5;
    sum      = 8'h3C;
    cin_cout = 1'b1;
    #1;
    n_checks++;
    if (out !== 8'hA5) $display("FAIL comb_out got=%h exp=a5", out);
    else n_pass++;
    n_checks++;
    if (cout_o !== 1'b1) $display("FAIL comb_cout_hi got=%b exp=1", cout_o);
    else n_pass++;
    cin_cout = 1'b0;
    #1;
    n_checks++;
    if (cout_o !== 1'b0) $display("FAIL comb_cout_lo got=%b exp=0", cout_o);
    else n_pass++;
    step();
  endtask

  task automatic test_registered();
    logic [16:0] v;
    v        = 17'h1FFFF;
    lut_o    = 8'hA5;
    sum      = 8'h3C;
    cin_cout = 1'b1;
    ce       = 1'b1;
    for (int i = 0; i < 17; i++) begin
      shift_bit(v[i]);
      if (i == 8) begin
        n_checks++;
        if (out !== 8'h00) $display("FAIL load_out_zero got=%h exp=00", out);
        else n_pass++;
        n_checks++;
        if (cout_o !== 1'b0) $display("FAIL load_cout_zero got=%b exp=0", cout_o);
        else n_pass++;
      end
    end
    n_checks++;
    if (out !== 8'h00) $display("FAIL load_end_out_zero got=%h exp=00", out);
    else n_pass++;
    cfg_en = 1'b0;
    #1;
    // registers held during the load although ce was high
    n_checks++;
    if (out !== 8'h00) $display("FAIL reg_held_in_load got=%h exp=00", out);
    else n_pass++;
    n_checks++;
    if (cout_o !== 1'b0) $display("FAIL creg_held_in_load got=%b exp=0", cout_o);
    else n_pass++;
    step();
    n_checks++;
    if (out !== 8'h3C) $display("FAIL reg_out got=%h exp=3c", out);
    else n_pass++;
    n_checks++;
    if (cout_o !== 1'b1) $display("FAIL reg_cout got=%b exp=1", cout_o);
    else n_pass++;
  endtask

  task automatic test_hold_clear();
    ce       = 1'b0;
    sum      = 8'h00;
    cin_cout = 1'b0;
    step();
    n_checks++;
    if (out !== 8'h3C) $display("FAIL hold_out got=%h exp=3c", out);
    else n_pass++;
    n_checks++;
    if (cout_o !== 1'b1) $display("FAIL hold_cout got=%b exp=1", cout_o);
    else n_pass++;
    sum      = 8'hFF;
    cin_cout = 1'b1;
    sr       = 1'b1;
    ce       = 1'b1;
    step();
    sr = 1'b0;
    ce = 1'b0;
    n_checks++;
    if (out !== 8'h00) $display("FAIL sr_out got=%h exp=00", out);
    else n_pass++;
    n_checks++;
    if (cout_o !== 1'b0) $display("FAIL sr_cout got=%b exp=0", cout_o);
    else n_pass++;
  endtask

  task automatic test_mixed();
    logic [16:0] v;
    v        = 17'h0F00F;
    lut_o    = 8'hAA;
    sum      = 8'h55;
    cin_cout = 1'b1;
    ce       = 1'b1;
    for (int i = 0; i < 17; i++) shift_bit(v[i]);
    n_checks++;
    if (out !== 8'h00) $display("FAIL mixed_in_load got=%h exp=00", out);
    else n_pass++;
    cfg_en = 1'b0;
    #1;
    n_checks++;
    if (out !== 8'h05) $display("FAIL mixed_immediate got=%h exp=05", out);
    else n_pass++;
    n_checks++;
    if (cout_o !== 1'b1) $display("FAIL mixed_cout_direct got=%b exp=1", cout_o);
    else n_pass++;
    step();
    n_checks++;
    if (out !== 8'hA5) $display("FAIL mixed_after_edge got=%h exp=a5", out);
    else n_pass++;
    cin_cout = 1'b0;
    #1;
    n_checks++;
    if (cout_o !== 1'b0) $display("FAIL mixed_cout_follow got=%b exp=0", cout_o);
    else n_pass++;
    ce = 1'b0;
  endtask

  task automatic test_chain_and_reset();
    logic [16:0] p;
    logic [16:0] q;
    logic [16:0] v;
    p = 17'h12D4B;
    q = 17'h0A5A5;
    for (int i = 0; i < 17; i++) shift_bit(p[i]);
    n_checks++;
    if (cfg_out !== p[0]) $display("FAIL chain_bit0 got=%b exp=%b", cfg_out, p[0]);
    else n_pass++;
    for (int m = 1; m < 17; m++) begin
      shift_bit(q[m-1]);
      n_checks++;
      if (cfg_out !== p[m]) $display("FAIL chain_bit%0d got=%b exp=%b", m, cfg_out, p[m]);
      else n_pass++;
    end
    // abort a load at bit 9 with reset
    v = 17'h1FFFF;
    for (int i = 0; i < 9; i++) shift_bit(v[i]);
    cfg_en   = 1'b0;
    lut_o    = 8'h69;
    sum      = 8'h96;
    cin_cout = 1'b1;
    rst_n    = 1'b0;
    #1;
    n_checks++;
    if (out !== 8'h69) $display("FAIL midload_rst_out got=%h exp=69", out);
    else n_pass++;
    n_checks++;
    if (cout_o !== 1'b1) $display("FAIL midload_rst_cout got=%b exp=1", cout_o);
    else n_pass++;
    n_checks++;
    if (cfg_out !== 1'b0) $display("FAIL midload_rst_cfg_out got=%b exp=0", cfg_out);
    else n_pass++;
    step();
    rst_n = 1'b1;
    step();
    // fresh load from bit 0: sel_sum only
    v     = 17'h000FF;
    sum   = 8'h3C;
    lut_o = 8'hC3;
    for (int i = 0; i < 17; i++) shift_bit(v[i]);
    cfg_en = 1'b0;
    #1;
    n_checks++;
    if (out !== 8'h3C) $display("FAIL reload_out got=%h exp=3c", out);
    else n_pass++;
    n_checks++;
    if (cfg_out !== 1'b1) $display("FAIL reload_cfg_out got=%b exp=1", cfg_out);
    else n_pass++;
    n_checks++;
    if (cout_o !== 1'b1) $display("FAIL reload_cout got=%b exp=1", cout_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_comb_path();
    test_registered();
    test_hold_clear();
    test_mixed();
    test_chain_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/slice_out_stage.md
SLICE_OUT_STAGE -- requirements
Module: slice_out_stage

Interface
REQ-001 Parameter W, default 8, SHALL set the slice data width (matches the 8-bit carry chain).
REQ-002 Parameter CFG_N, default 2*W+1, SHALL set the configuration chain length; it is not overridable independently of W.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 cfg_en  input  1  SHALL be the config shift enable.
REQ-006 cfg_in  input  1  SHALL be the serial config data in.
REQ-007 cfg_out  output  1  SHALL be the serial config data out, for daisy-chaining to the next slice.
REQ-008 ce  input  1  SHALL be the data register clock enable.
REQ-009 sr  input  1  SHALL be the synchronous clear of the data registers.
REQ-010 lut_o  input  W  SHALL carry the per-bit LUT outputs.
REQ-011 sum  input  W  SHALL carry the carry-chain sum bits (S).
REQ-012 cin_cout  input  1  SHALL carry the carry-chain carry-out (COUT).
REQ-013 out  output  W  SHALL carry the slice outputs to routing.
REQ-014 cout_o  output  1  SHALL carry the slice carry-out to routing.

Function
REQ-015 Config SHALL be held in a shift register cfg[CFG_N-1:0]; with cfg_en=1 each edge does cfg <= {cfg_in, cfg[CFG_N-1:1]}; with cfg_en=0 cfg holds.
REQ-016 cfg_out SHALL equal cfg[0], registered, with no combinational path from cfg_in.
REQ-017 Field map: cfg[W-1:0]=sel_sum[i], cfg[2W-1:W]=sel_reg[i], cfg[2W]=cout_reg.
REQ-018 Per-bit data d[i] SHALL equal sum[i] when sel_sum[i]=1, else lut_o[i].
REQ-019 Data register q[i] SHALL update as follows: sr=1 -> 0; else ce=1 -> d[i]; else hold. sr has priority over ce.
REQ-020 Carry register cq SHALL follow the same rule with d=cin_cout.
REQ-021 While cfg_en=1, q and cq SHALL hold, regardless of ce; sr still clears them.
REQ-022 out[i] SHALL be 0 while cfg_en=1; otherwise q[i] if sel_reg[i]=1, else d[i] (combinational, zero latency).
REQ-023 cout_o SHALL be 0 while cfg_en=1; otherwise cq if cout_reg=1, else cin_cout.
REQ-024 Registered path latency SHALL be exactly 1 edge with ce=1; combinational path latency SHALL be 0.
REQ-025 A full config load SHALL take exactly CFG_N edges with cfg_en=1; the first bit shifted in lands in cfg[0].
REQ-026 Config changes SHALL take effect on out/cout_o in the same cycle cfg_en falls.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear cfg, q, cq, and the cfg_out register to 0.
REQ-028 After reset, out SHALL equal lut_o (combinational) and cout_o SHALL equal cin_cout.
REQ-029 Reset asserted mid-load SHALL discard partial config; the load restarts from bit 0 after release.

Structure
REQ-030 Shared package slice_pkg SHALL hold W and the field-offset constants (SEL_SUM_LO, SEL_REG_LO, COUT_REG_BIT, CFG_N).
REQ-031 The config chain SHALL be a sub-module cfg_shift_reg (width CFG_N, en, sin, sout, parallel q), reused by other fabric blocks.
REQ-032 The block SHALL instantiate no latches; all state SHALL be flops on clk.

Verification
REQ-033 Reset, then lut_o=8'hA5, sum=8'h3C -> out=8'hA5 the same cycle; cout_o follows cin_cout.
REQ-034 Shift 17 bits loading sel_sum=8'hFF, sel_reg=8'hFF, cout_reg=1; apply sum=8'h3C, cin_cout=1, ce=1 -> out=0 during the load; out=8'h3C and cout_o=1 one edge after the inputs.
REQ-035 Registered config, q=8'h3C; set ce=0 and change sum to 8'h00 -> out stays 8'h3C; then sr=1 with ce=1 -> out=8'h00 next edge.
REQ-036 Mixed config sel_sum=8'h0F, sel_reg=8'hF0; lut_o=8'hAA, sum=8'h55, ce=1 -> out[3:0]=4'h5 immediately; out[7:4]=4'hA after one edge.
REQ-037 Shift a 17-bit pattern into cfg_in -> the same pattern appears on cfg_out delayed 17 edges; assert rst_n low at bit 9 -> cfg all 0 and out=lut_o immediately.
